// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the device with the host-request sequence:
// inhibit the clock, pull data low for the start bit, then release the clock.
// Data changes on each device clock fall. The ACK bit is sampled on the 11th fall.
// The open-drain pads are built at the top level from the *_oe outputs (1 = pull low).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    // One counter serves both the inhibit interval and the inter-edge timeout.
    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                  : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    // Line synchronizers (idle level of both lines is high)
    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;
    logic fall;

    // Frame state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             ack_err_r_q, ack_err_r_d;

    // Registered outputs
    logic clk_oe_q, clk_oe_d;
    logic dat_oe_q, dat_oe_d;
    logic busy_q, busy_d;
    logic tx_ready_q, tx_ready_d;
    logic done_q, done_d;
    logic ack_err_q, ack_err_d;
    logic timeout_err_q, timeout_err_d;

    // Set in the states where the inter-edge watchdog advances this cycle
    logic run_timer;

    assign fall = clk_prev_q & ~clk_sync_q;

    // Two-flop synchronizers on both lines plus the previous synchronized clock for edge detection
    always_ff @(posedge CLOCK_50 or negedge clrn) begin
        if (!clrn) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Next-state and next-output logic for the transmit sequence
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        ack_err_r_d   = ack_err_r_q;
        clk_oe_d      = clk_oe_q;
        dat_oe_d      = dat_oe_q;
        busy_d        = busy_q;
        tx_ready_d    = tx_ready_q;
        done_d        = 1'b0;
        ack_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        run_timer     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (!tx_ready_q) begin
                    // Cycle carrying done/timeout_err: finish the frame, become ready next cycle
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else if (tx_valid) begin
                    shift_d     = tx_data;
                    parity_d    = ~^tx_data;
                    ack_err_r_d = 1'b0;
                    cnt_d       = '0;
                    bit_cnt_d   = '0;
                    tx_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                    clk_oe_d    = 1'b1;
                    state_d     = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                // Clock held low; device edges seen here are ignored
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = ST_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_REQ: begin
                // Start bit stays on DAT while CLK is handed back to the device
                clk_oe_d  = 1'b0;
                dat_oe_d  = 1'b1;
                cnt_d     = '0;
                bit_cnt_d = '0;
                state_d   = ST_SEND;
            end

            ST_SEND: begin
                if (fall) begin
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        // Data bits, LSB first; a 1 is sent by releasing the line
                        dat_oe_d = ~shift_q[0];
                        shift_d  = {1'b0, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        dat_oe_d = ~parity_q;
                    end else begin
                        // Stop bit: release DAT so the device can drive the ACK
                        dat_oe_d = 1'b0;
                        state_d  = ST_ACK;
                    end
                end else begin
                    run_timer = 1'b1;
                end
            end

            ST_ACK: begin
                if (fall) begin
                    cnt_d       = '0;
                    ack_err_r_d = dat_sync_q;
                    state_d     = ST_WAIT_IDLE;
                end else begin
                    run_timer = 1'b1;
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_sync_q && dat_sync_q) begin
                    done_d    = 1'b1;
                    ack_err_d = ack_err_r_q;
                    clk_oe_d  = 1'b0;
                    dat_oe_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (fall) begin
                    cnt_d = '0;
                end else begin
                    run_timer = 1'b1;
                end
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        // Watchdog: abort the frame if the device stops clocking
        if (run_timer) begin
            if (cnt_q == TIMEOUT_LAST) begin
                cnt_d         = '0;
                clk_oe_d      = 1'b0;
                dat_oe_d      = 1'b0;
                timeout_err_d = 1'b1;
                state_d       = ST_IDLE;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // State, datapath and output registers; reset releases both lines at once
    always_ff @(posedge CLOCK_50 or negedge clrn) begin
        if (!clrn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            ack_err_r_q   <= 1'b0;
            clk_oe_q      <= 1'b0;
            dat_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            tx_ready_q    <= 1'b1;
            done_q        <= 1'b0;
            ack_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            ack_err_r_q   <= ack_err_r_d;
            clk_oe_q      <= clk_oe_d;
            dat_oe_q      <= dat_oe_d;
            busy_q        <= busy_d;
            tx_ready_q    <= tx_ready_d;
            done_q        <= done_d;
            ack_err_q     <= ack_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_dat_oe  = dat_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device on the line.
module tb_ps2_host_tx;

    localparam int INH  = 5000;
    localparam int TMO  = 1000;
    localparam int HALF = 20;

    logic       CLOCK_50 = 1'b0;
    logic       clrn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    // Device side of the open-drain wires
    logic dev_clk_low;
    logic dev_dat_low;
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: expected dat_oe after each fall, and what the device saw
    logic exp_q[$];
    logic obs_q[$];
    logic exp_ack_q[$];

    // Monitor counters
    int done_cnt = 0;
    int tmo_cnt  = 0;
    int ack_viol = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .clrn       (clrn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout_err(timeout_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (done === 1'b1) done_cnt++;
        if (timeout_err === 1'b1) tmo_cnt++;
        if (ack_err === 1'b1 && done !== 1'b1) ack_viol++;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected dat_oe after falls 1..10 for byte d
    task automatic push_expected(input logic [7:0] d, input int nbits);
        logic par;
        logic [9:0] slots;
        par = ~^d;
        for (int i = 0; i < 8; i++) slots[i] = ~d[i];
        slots[8] = ~par;
        slots[9] = 1'b0;
        for (int i = 0; i < nbits; i++) exp_q.push_back(slots[i]);
    endtask

    // Present a byte and wait for the handshake; returns at the negedge after acceptance
    task automatic send(input logic [7:0] d, input bit hold, output bit ok);
        int guard;
        guard = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && guard < 20000) begin
            @(negedge CLOCK_50);
            guard++;
        end
        ok = (tx_ready === 1'b1);
        @(negedge CLOCK_50);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Device: wait for the request-to-send, then generate nfalls clock pulses
    task automatic dev_frame(input int nfalls, input bit do_ack, output bit ok);
        int guard;
        guard = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && guard < INH + 100) begin
            @(negedge CLOCK_50);
            guard++;
        end
        ok = (ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1);
        if (ok) begin
            repeat (HALF) @(negedge CLOCK_50);
            for (int k = 1; k <= nfalls; k++) begin
                if (k == 11 && do_ack) begin
                    dev_dat_low = 1'b1;
                    repeat (2) @(negedge CLOCK_50);
                end
                dev_clk_low = 1'b1;
                repeat (HALF) @(negedge CLOCK_50);
                if (k <= 10) obs_q.push_back(ps2_dat_oe);
                dev_clk_low = 1'b0;
                dev_dat_low = 1'b0;
                if (k < nfalls) repeat (HALF) @(negedge CLOCK_50);
            end
        end
    endtask

    // Wait (bounded) for the done pulse; returns on the negedge where done is high
    task automatic wait_done(output bit ok);
        int guard;
        guard = 0;
        while (done !== 1'b1 && guard < 300) begin
            @(negedge CLOCK_50);
            guard++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        clrn        = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        n_tests++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        n_tests++;
        if ({busy, ps2_clk_oe, ps2_dat_oe} !== 3'b000) begin
            n_fail++; $display("FAIL reset_busy_oe: got %b want 000", {busy, ps2_clk_oe, ps2_dat_oe});
        end
        n_tests++;
        if ({done, ack_err, timeout_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 000", {done, ack_err, timeout_err});
        end
        clrn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        n_tests++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
            n_fail++; $display("FAIL idle_after_reset: got %b want 1000", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_send_ed();
        bit ok;
        logic e, o, ea;
        push_expected(8'hED, 10);
        exp_ack_q.push_back(1'b0);
        send(8'hED, 1'b0, ok);
        dev_frame(11, 1'b1, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL ed_request: no request-to-send seen, got 0 want 1"); end
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL ed_bit%0d: dat_oe=%b want %b", i + 1, o, e); end
        end
        wait_done(ok);
        ea = exp_ack_q.pop_front();
        n_tests++;
        if (!ok || ack_err !== ea) begin n_fail++; $display("FAIL ed_done_ack: done=%b ack_err=%b want 1/%b", done, ack_err, ea); end
        @(negedge CLOCK_50);
        n_tests++;
        if ({busy, tx_ready} !== 2'b01) begin n_fail++; $display("FAIL ed_after_done: busy,tx_ready=%b want 01", {busy, tx_ready}); end
        repeat (10) @(negedge CLOCK_50);
    endtask

    task automatic test_timing_07();
        bit ok;
        int c;
        logic e, o, ea;
        push_expected(8'h07, 10);
        exp_ack_q.push_back(1'b0);
        send(8'h07, 1'b0, ok);
        c = 0;
        while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && c < INH + 20) begin
            c++;
            @(negedge CLOCK_50);
        end
        n_tests++;
        if (c != INH) begin n_fail++; $display("FAIL inhibit_len: %0d cycles want %0d", c, INH); end
        n_tests++;
        if ({ps2_clk_oe, ps2_dat_oe} !== 2'b11) begin n_fail++; $display("FAIL req_cycle: oe=%b want 11", {ps2_clk_oe, ps2_dat_oe}); end
        @(negedge CLOCK_50);
        n_tests++;
        if ({ps2_clk_oe, ps2_dat_oe} !== 2'b01) begin n_fail++; $display("FAIL send_entry: oe=%b want 01", {ps2_clk_oe, ps2_dat_oe}); end
        dev_frame(11, 1'b1, ok);
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL x07_bit%0d: dat_oe=%b want %b", i + 1, o, e); end
        end
        wait_done(ok);
        ea = exp_ack_q.pop_front();
        n_tests++;
        if (!ok || ack_err !== ea) begin n_fail++; $display("FAIL x07_done_ack: done=%b ack_err=%b want 1/%b", done, ack_err, ea); end
        repeat (10) @(negedge CLOCK_50);
    endtask

    task automatic test_no_ack_ff();
        bit ok;
        logic e, o, ea;
        push_expected(8'hFF, 10);
        exp_ack_q.push_back(1'b1);
        send(8'hFF, 1'b0, ok);
        dev_frame(11, 1'b0, ok);
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL xff_bit%0d: dat_oe=%b want %b", i + 1, o, e); end
        end
        wait_done(ok);
        ea = exp_ack_q.pop_front();
        n_tests++;
        if (!ok || ack_err !== ea) begin n_fail++; $display("FAIL xff_done_ack: done=%b ack_err=%b want 1/%b", done, ack_err, ea); end
        n_tests++;
        if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL xff_ready_in_done: tx_ready=%b want 0", tx_ready); end
        @(negedge CLOCK_50);
        n_tests++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL xff_ready_after: tx_ready=%b want 1", tx_ready); end
        repeat (10) @(negedge CLOCK_50);
    endtask

    task automatic test_timeout_00();
        bit ok;
        int c, guard, d0;
        d0 = done_cnt;
        send(8'h00, 1'b0, ok);
        guard = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && guard < INH + 100) begin
            @(negedge CLOCK_50);
            guard++;
        end
        c = 0;
        while (timeout_err !== 1'b1 && c < TMO + 50) begin
            @(negedge CLOCK_50);
            c++;
        end
        n_tests++;
        if (c != TMO) begin n_fail++; $display("FAIL timeout_len: %0d cycles want %0d", c, TMO); end
        n_tests++;
        if ({ps2_clk_oe, ps2_dat_oe, done} !== 3'b000) begin
            n_fail++; $display("FAIL timeout_oe_done: clk_oe,dat_oe,done=%b want 000", {ps2_clk_oe, ps2_dat_oe, done});
        end
        @(negedge CLOCK_50);
        n_tests++;
        if ({tx_ready, busy, timeout_err} !== 3'b100) begin
            n_fail++; $display("FAIL timeout_after: tx_ready,busy,timeout_err=%b want 100", {tx_ready, busy, timeout_err});
        end
        repeat (20) @(negedge CLOCK_50);
        n_tests++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL timeout_no_done: %0d done pulses want 0", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_f4();
        bit ok;
        int d0, t0;
        logic e, o, ea;
        push_expected(8'hF4, 4);
        send(8'hF4, 1'b0, ok);
        dev_frame(4, 1'b0, ok);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL f4_part_bit%0d: dat_oe=%b want %b", i + 1, o, e); end
        end
        d0 = done_cnt;
        t0 = tmo_cnt;
        @(negedge CLOCK_50);
        #3;
        clrn = 1'b0;
        #1;
        n_tests++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
            n_fail++; $display("FAIL async_reset: clk_oe,dat_oe,busy=%b want 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
        repeat (3) @(negedge CLOCK_50);
        clrn = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        n_tests++;
        if (done_cnt != d0 || tmo_cnt != t0) begin
            n_fail++; $display("FAIL reset_no_pulse: done %0d timeout %0d want 0 0", done_cnt - d0, tmo_cnt - t0);
        end
        push_expected(8'hF4, 10);
        exp_ack_q.push_back(1'b0);
        send(8'hF4, 1'b0, ok);
        dev_frame(11, 1'b1, ok);
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL f4_bit%0d: dat_oe=%b want %b", i + 1, o, e); end
        end
        wait_done(ok);
        ea = exp_ack_q.pop_front();
        n_tests++;
        if (!ok || ack_err !== ea) begin n_fail++; $display("FAIL f4_done_ack: done=%b ack_err=%b want 1/%b", done, ack_err, ea); end
        repeat (10) @(negedge CLOCK_50);
    endtask

    task automatic test_busy_ignore();
        bit ok;
        int d0;
        logic e, o, ea;
        d0 = done_cnt;
        push_expected(8'h55, 10);
        exp_ack_q.push_back(1'b0);
        send(8'h55, 1'b0, ok);
        repeat (10) @(negedge CLOCK_50);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
        dev_frame(11, 1'b1, ok);
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL x55_bit%0d: dat_oe=%b want %b", i + 1, o, e); end
        end
        wait_done(ok);
        ea = exp_ack_q.pop_front();
        n_tests++;
        if (!ok || ack_err !== ea) begin n_fail++; $display("FAIL x55_done_ack: done=%b ack_err=%b want 1/%b", done, ack_err, ea); end
        repeat (60) @(negedge CLOCK_50);
        n_tests++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL x55_done_count: %0d pulses want 1", done_cnt - d0); end
        n_tests++;
        if ({busy, ps2_clk_oe} !== 2'b00) begin n_fail++; $display("FAIL x55_no_second_frame: busy,clk_oe=%b want 00", {busy, ps2_clk_oe}); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic e, o, ea;
        push_expected(8'h3C, 10);
        exp_ack_q.push_back(1'b0);
        send(8'h3C, 1'b1, ok);
        dev_frame(11, 1'b1, ok);
        wait_done(ok);
        ea = exp_ack_q.pop_front();
        n_tests++;
        if (!ok || ack_err !== ea) begin n_fail++; $display("FAIL b2b_first_ack: done=%b ack_err=%b want 1/%b", done, ack_err, ea); end
        tx_data = 8'hA5;
        @(negedge CLOCK_50);
        n_tests++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: tx_ready=%b want 1", tx_ready); end
        @(negedge CLOCK_50);
        n_tests++;
        if ({busy, ps2_clk_oe, tx_ready} !== 3'b110) begin
            n_fail++; $display("FAIL b2b_accept: busy,clk_oe,tx_ready=%b want 110", {busy, ps2_clk_oe, tx_ready});
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL x3c_bit%0d: dat_oe=%b want %b", i + 1, o, e); end
        end
        push_expected(8'hA5, 10);
        exp_ack_q.push_back(1'b0);
        dev_frame(11, 1'b1, ok);
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            o = 1'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL xa5_bit%0d: dat_oe=%b want %b", i + 1, o, e); end
        end
        wait_done(ok);
        ea = exp_ack_q.pop_front();
        n_tests++;
        if (!ok || ack_err !== ea) begin n_fail++; $display("FAIL b2b_second_ack: done=%b ack_err=%b want 1/%b", done, ack_err, ea); end
        repeat (10) @(negedge CLOCK_50);
    endtask

    task automatic test_ack_err_hold();
        n_tests++;
        if (ack_viol != 0) begin n_fail++; $display("FAIL ack_err_hold: %0d cycles with ack_err outside done, want 0", ack_viol); end
        n_tests++;
        if (exp_ack_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d results pending, want 0", exp_ack_q.size()); end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_timing_07();
        test_no_ack_ff();
        test_timeout_00();
        test_reset_mid_f4();
        test_busy_ignore();
        test_back_to_back();
        test_ack_err_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the host-request protocol, then checks the device ACK bit.
- Sits beside the existing PS/2 receive path on the same PS2_CLK/PS2_DAT pair. The top level builds the open-drain tristate from this block's *_oe outputs.
- While busy is high, the receive path must ignore line activity.

Parameters:
- INHIBIT_CYCLES, 5000: cycles the clock line is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles allowed between accept/falling edges before abort (15 ms at 50 MHz).

Ports:
- CLOCK_50  in  1: system clock; all logic on posedge.
- clrn  in  1: reset, asynchronous, active-low.
- tx_data  in  8: command byte.
- tx_valid  in  1: request to send tx_data.
- tx_ready  out  1: high only in IDLE; transfer happens when tx_valid & tx_ready.
- ps2_clk_in  in  1: raw PS2_CLK line level.
- ps2_dat_in  in  1: raw PS2_DAT line level.
- ps2_clk_oe  out  1: 1 = drive PS2_CLK low; 0 = release (high-Z).
- ps2_dat_oe  out  1: 1 = drive PS2_DAT low; 0 = release.
- busy  out  1: high from accept until return to IDLE.
- done  out  1: one-cycle pulse when a frame completes, with or without ACK.
- ack_err  out  1: valid while done=1; 1 = device did not ACK.
- timeout_err  out  1: one-cycle pulse on abort.

Behaviour:
- Reset (clrn=0, async): state=IDLE; all outputs 0 except tx_ready=1; counters 0; synchronizers preset to 1.
- Line inputs: 2-flop synchronizer on each line, plus a registered previous value of the synchronized clock.
  - fall = prev_clk & ~sync_clk.
  - Only the synchronized values are used for decisions.
- Shift register: 8 bits, latched at accept. Parity = ~^tx_data (odd parity). Bit counter counts 0..10.
- IDLE:
  - tx_ready=1, busy=0, both oe=0.
  - On tx_valid: latch data and compute parity; go to INHIBIT; busy=1 from the next cycle.
- INHIBIT:
  - clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles; then go to REQ.
- REQ (1 cycle): clk_oe=1, dat_oe=1 (start bit). Then go to SEND.
- SEND:
  - clk_oe=0; timeout counter cleared on entry.
  - On each fall, counted n=1..10, dat_oe is updated in the same cycle as fall is detected:
    - n=1..8: dat_oe = ~tx_data[n-1], so bit 0 goes first.
    - n=9: dat_oe = ~parity.
    - n=10: dat_oe = 0 (stop bit = release).
  - After n=10, go to ACK.
- ACK:
  - On the next fall (11th), sample sync_dat: ack_err_r = sync_dat (0 = ACK). Go to WAIT_IDLE.
- WAIT_IDLE:
  - When sync_clk=1 and sync_dat=1: pulse done with ack_err=ack_err_r, then IDLE.
  - tx_ready returns 1 the cycle after done.
- Timeout:
  - Counter runs in SEND, ACK and WAIT_IDLE, and clears on every fall.
  - Reaching TIMEOUT_CYCLES:
    - both oe=0;
    - timeout_err pulses one cycle;
    - no done pulse;
    - go to IDLE.
- Boundary conditions:
  - tx_valid while busy: ignored; data not latched.
  - A fall during INHIBIT or REQ (device fighting the line): ignored; the bit counter does not advance.
  - Reset mid-frame: oe deassert immediately (async); no done/timeout_err pulse.
  - Back-to-back: tx_valid held high through done → the next frame is accepted in the first IDLE cycle.
  - ack_err is held 0 except in the done cycle.

Test Plan:
- Send 0xED; device model clocks 11 edges and ACKs → dat_oe sequence over falls 1..10 = ~(1,0,1,1,0,1,1,1,1,0 stop→0); done=1, ack_err=0, busy drops after done.
- Send 0x07, checking timing → ps2_clk_oe high for exactly 5000 cycles, then 1 cycle with both oe=1 → parity slot dat_oe=1 (parity 0); done, ack_err=0.
- Send 0xFF; device leaves DAT high at the 11th edge → done=1 with ack_err=1; tx_ready=1 the next cycle.
- Send 0x00; device never clocks (TIMEOUT_CYCLES=1000 in bench) → timeout_err pulse 1000 cycles after entering SEND; no done; both oe=0; tx_ready=1.
- Assert clrn=0 after the 4th fall of a 0xF4 frame → ps2_clk_oe=ps2_dat_oe=0 asynchronously, busy=0; after release, a new 0xF4 send completes with ack_err=0.
- Pulse tx_valid with 0xAA while busy sending 0x55 → 0xAA is ignored; the observed bit sequence is that of 0x55 only; exactly one done pulse.
